// File: rtl/stepdown_seq_pkg.sv
// Shared types and default constants for the stepdown core state sequencer.
package stepdown_seq_pkg;

  localparam int STATE_W         = 3;
  localparam int SS_W_DEF        = 4;
  localparam int SS_STEP_CYC_DEF = 4;
  localparam int PRECHG_CYC_DEF  = 8;
  localparam int RETRY_CYC_DEF   = 32;
  localparam int OCP_MAX_DEF     = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF       = 3'd0,
    ST_PRECHG    = 3'd1,
    ST_SOFTSTART = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  // Counter width for a count of n cycles; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stepdown_sync2.sv
// Two-flop synchronizer for the asynchronous overcurrent comparator.
module stepdown_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/stepdown_core_state_seq.sv
// Stepdown core state sequencer: bootstrap precharge, soft-start ramp, run and OCP retry/latch-off.
module stepdown_core_state_seq
  import stepdown_seq_pkg::*;
#(
  parameter int SS_W        = SS_W_DEF,
  parameter int SS_STEP_CYC = SS_STEP_CYC_DEF,
  parameter int PRECHG_CYC  = PRECHG_CYC_DEF,
  parameter int RETRY_CYC   = RETRY_CYC_DEF,
  parameter int OCP_MAX     = OCP_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               CELV,
  input  logic               CELG,
  input  logic               SUB,
  input  logic               en,
  input  logic               uvlo_ok,
  input  logic               ocp_a,
  output logic               ls_on,
  output logic               sw_en,
  output logic [SS_W-1:0]    ss_code,
  output logic               pgood,
  output logic               fault,
  output logic [STATE_W-1:0] state
);

  localparam int PRE_W   = cnt_w(PRECHG_CYC);
  localparam int STEP_W  = cnt_w(SS_STEP_CYC);
  localparam int RETRY_W = cnt_w(RETRY_CYC);
  localparam int OCP_W   = cnt_w(OCP_MAX + 1);

  localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(PRECHG_CYC - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(SS_STEP_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_CYC - 1);
  localparam logic [OCP_W-1:0]   OCP_LIM    = OCP_W'(OCP_MAX);
  localparam logic [SS_W-1:0]    SS_MAX     = '1;

  logic unused_pins;
  assign unused_pins = CELV ^ CELG ^ SUB;

  logic ocp_s;
  logic go;

  state_t             state_q, state_n;
  logic [SS_W-1:0]    ss_q, ss_n;
  logic [OCP_W-1:0]   ocp_cnt_q, ocp_cnt_n;
  logic [PRE_W-1:0]   prechg_cnt;
  logic [STEP_W-1:0]  step_cnt;
  logic [RETRY_W-1:0] retry_cnt;

  stepdown_sync2 u_ocp_sync (
    .clk (clk),
    .rst (rst),
    .d   (ocp_a),
    .q   (ocp_s)
  );

  assign go    = en && uvlo_ok;
  assign state = state_q;

  // Next-state is shared by the state register and the output register so outputs track state.
  always_comb begin
    state_n   = state_q;
    ss_n      = ss_q;
    ocp_cnt_n = ocp_cnt_q;
    if (state_q != ST_OFF && !go) begin
      state_n   = ST_OFF;
      ss_n      = '0;
      ocp_cnt_n = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (go) state_n = ST_PRECHG;
        end
        ST_PRECHG: begin
          if (prechg_cnt == PRE_LAST) begin
            state_n = ST_SOFTSTART;
            ss_n    = '0;
          end
        end
        ST_SOFTSTART, ST_RUN: begin
          if (ocp_s) begin
            state_n = ST_FAULT;
            ss_n    = '0;
            if (ocp_cnt_q != OCP_LIM) ocp_cnt_n = ocp_cnt_q + OCP_W'(1);
          end else if (state_q == ST_RUN) begin
            ocp_cnt_n = '0;
          end else if (step_cnt == STEP_LAST) begin
            if (ss_q == SS_MAX) state_n = ST_RUN;
            else                ss_n    = ss_q + SS_W'(1);
          end
        end
        ST_FAULT: begin
          if (ocp_cnt_q != OCP_LIM && retry_cnt == RETRY_LAST) state_n = ST_PRECHG;
        end
        default: begin
          state_n   = ST_OFF;
          ss_n      = '0;
          ocp_cnt_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_OFF;
      ss_q       <= '0;
      ocp_cnt_q  <= '0;
      prechg_cnt <= '0;
      step_cnt   <= '0;
      retry_cnt  <= '0;
    end else begin
      state_q    <= state_n;
      ss_q       <= ss_n;
      ocp_cnt_q  <= ocp_cnt_n;
      prechg_cnt <= (state_q == ST_PRECHG && state_n == ST_PRECHG) ? prechg_cnt + PRE_W'(1) : '0;
      step_cnt   <= (state_q == ST_SOFTSTART && state_n == ST_SOFTSTART && step_cnt != STEP_LAST)
                    ? step_cnt + STEP_W'(1) : '0;
      // Retry timer only runs while a retry is still allowed; a latched fault holds it at zero.
      retry_cnt  <= (state_q == ST_FAULT && state_n == ST_FAULT && ocp_cnt_q != OCP_LIM)
                    ? retry_cnt + RETRY_W'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ls_on   <= 1'b0;
      sw_en   <= 1'b0;
      pgood   <= 1'b0;
      fault   <= 1'b0;
      ss_code <= '0;
    end else begin
      ls_on   <= (state_n == ST_PRECHG);
      sw_en   <= (state_n == ST_SOFTSTART) || (state_n == ST_RUN);
      pgood   <= (state_n == ST_RUN);
      fault   <= (state_n == ST_FAULT);
      ss_code <= ((state_n == ST_SOFTSTART) || (state_n == ST_RUN)) ? ss_n : '0;
    end
  end

endmodule

// File: tb/tb_stepdown_core_state_seq.sv
// Directed bench for the stepdown core state sequencer.
module tb_stepdown_core_state_seq;

  logic       clk;
  logic       rst;
  logic       en;
  logic       uvlo_ok;
  logic       ocp_a;
  logic       ls_on;
  logic       sw_en;
  logic [3:0] ss_code;
  logic       pgood;
  logic       fault;
  logic [2:0] state;

  int tests;
  int fails;

  logic [10:0] obs;
  assign obs = {state, ls_on, sw_en, pgood, fault, ss_code};

  stepdown_core_state_seq #(
    .SS_W        (4),
    .SS_STEP_CYC (4),
    .PRECHG_CYC  (8),
    .RETRY_CYC   (32),
    .OCP_MAX     (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .CELV    (1'b1),
    .CELG    (1'b0),
    .SUB     (1'b0),
    .en      (en),
    .uvlo_ok (uvlo_ok),
    .ocp_a   (ocp_a),
    .ls_on   (ls_on),
    .sw_en   (sw_en),
    .ss_code (ss_code),
    .pgood   (pgood),
    .fault   (fault),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Packs {state, ls_on, sw_en, pgood, fault, ss_code} as the bench expects to see them.
  function automatic logic [10:0] expv(input int st, input int ls, input int sw,
                                       input int pg, input int ft, input int ss);
    return {3'(st), 1'(ls), 1'(sw), 1'(pg), 1'(ft), 4'(ss)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; uvlo_ok = 1'b0; ocp_a = 1'b0;
    step(3);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      tests++;
      if (obs !== expv(0, 0, 0, 0, 0, 0)) begin
        fails++;
        $display("FAIL reset_idle c%0d: got %b want %b", c, obs, expv(0, 0, 0, 0, 0, 0));
      end
    end
  endtask

  task automatic test_startup();
    logic [10:0] exp;
    en = 1'b1; uvlo_ok = 1'b1;
    for (int e = 1; e <= 73; e++) begin
      step(1);
      if (e <= 8)       exp = expv(1, 1, 0, 0, 0, 0);
      else if (e <= 72) exp = expv(2, 0, 1, 0, 0, (e - 9) / 4);
      else              exp = expv(3, 0, 1, 1, 0, 15);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL startup e%0d: got %b want %b", e, obs, exp);
      end
    end
  endtask

  task automatic test_ocp_retry();
    step(2);
    ocp_a = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      step(1);
      tests++;
      if (obs !== expv(3, 0, 1, 1, 0, 15)) begin
        fails++;
        $display("FAIL ocp_sync_delay e%0d: got %b want %b", e, obs, expv(3, 0, 1, 1, 0, 15));
      end
    end
    step(1);
    ocp_a = 1'b0;
    for (int e = 3; e <= 34; e++) begin
      tests++;
      if (obs !== expv(4, 0, 0, 0, 1, 0)) begin
        fails++;
        $display("FAIL ocp_fault_hold e%0d: got %b want %b", e, obs, expv(4, 0, 0, 0, 1, 0));
      end
      step(1);
    end
    tests++;
    if (obs !== expv(1, 1, 0, 0, 0, 0)) begin
      fails++;
      $display("FAIL ocp_retry_prechg: got %b want %b", obs, expv(1, 1, 0, 0, 0, 0));
    end
    step(8);
    tests++;
    if (obs !== expv(2, 0, 1, 0, 0, 0)) begin
      fails++;
      $display("FAIL ocp_restart_ss0: got %b want %b", obs, expv(2, 0, 1, 0, 0, 0));
    end
    step(4);
    tests++;
    if (obs !== expv(2, 0, 1, 0, 0, 1)) begin
      fails++;
      $display("FAIL ocp_restart_ss1: got %b want %b", obs, expv(2, 0, 1, 0, 0, 1));
    end
  endtask

  task automatic test_latch();
    en = 1'b0;
    step(1);
    tests++;
    if (obs !== expv(0, 0, 0, 0, 0, 0)) begin
      fails++;
      $display("FAIL latch_pre_off: got %b want %b", obs, expv(0, 0, 0, 0, 0, 0));
    end
    step(2);
    en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      for (int i = 0; i < 40 && state !== 3'd2; i++) step(1);
      tests++;
      if (state !== 3'd2) begin
        fails++;
        $display("FAIL latch_wait_ss k%0d: got state %0d want 2", k, state);
      end
      ocp_a = 1'b1;
      step(1);
      ocp_a = 1'b0;
      step(2);
      tests++;
      if (obs !== expv(4, 0, 0, 0, 1, 0)) begin
        fails++;
        $display("FAIL latch_enter k%0d: got %b want %b", k, obs, expv(4, 0, 0, 0, 1, 0));
      end
      if (k < 3) begin
        step(31);
        tests++;
        if (obs !== expv(4, 0, 0, 0, 1, 0)) begin
          fails++;
          $display("FAIL latch_retry_hold k%0d: got %b want %b", k, obs, expv(4, 0, 0, 0, 1, 0));
        end
        step(1);
        tests++;
        if (obs !== expv(1, 1, 0, 0, 0, 0)) begin
          fails++;
          $display("FAIL latch_retry_prechg k%0d: got %b want %b", k, obs, expv(1, 1, 0, 0, 0, 0));
        end
      end else begin
        step(32);
        tests++;
        if (obs !== expv(4, 0, 0, 0, 1, 0)) begin
          fails++;
          $display("FAIL latch_past_retry: got %b want %b", obs, expv(4, 0, 0, 0, 1, 0));
        end
        step(10);
        tests++;
        if (obs !== expv(4, 0, 0, 0, 1, 0)) begin
          fails++;
          $display("FAIL latch_held: got %b want %b", obs, expv(4, 0, 0, 0, 1, 0));
        end
      end
    end
    en = 1'b0;
    step(1);
    tests++;
    if (obs !== expv(0, 0, 0, 0, 0, 0)) begin
      fails++;
      $display("FAIL latch_exit_off: got %b want %b", obs, expv(0, 0, 0, 0, 0, 0));
    end
    step(1);
    en = 1'b1;
    step(1);
    tests++;
    if (obs !== expv(1, 1, 0, 0, 0, 0)) begin
      fails++;
      $display("FAIL fresh_prechg: got %b want %b", obs, expv(1, 1, 0, 0, 0, 0));
    end
    step(8);
    tests++;
    if (obs !== expv(2, 0, 1, 0, 0, 0)) begin
      fails++;
      $display("FAIL fresh_ss: got %b want %b", obs, expv(2, 0, 1, 0, 0, 0));
    end
    step(64);
    tests++;
    if (obs !== expv(3, 0, 1, 1, 0, 15)) begin
      fails++;
      $display("FAIL fresh_run: got %b want %b", obs, expv(3, 0, 1, 1, 0, 15));
    end
  endtask

  task automatic test_priority();
    en = 1'b0;
    step(1);
    step(3);
    en = 1'b1;
    step(9);
    tests++;
    if (obs !== expv(2, 0, 1, 0, 0, 0)) begin
      fails++;
      $display("FAIL prio_ss_entry: got %b want %b", obs, expv(2, 0, 1, 0, 0, 0));
    end
    ocp_a = 1'b1;
    step(2);
    tests++;
    if (obs !== expv(2, 0, 1, 0, 0, 0)) begin
      fails++;
      $display("FAIL prio_ss_before: got %b want %b", obs, expv(2, 0, 1, 0, 0, 0));
    end
    en = 1'b0;
    step(1);
    tests++;
    if (obs !== expv(0, 0, 0, 0, 0, 0)) begin
      fails++;
      $display("FAIL prio_en_over_ocp: got %b want %b", obs, expv(0, 0, 0, 0, 0, 0));
    end
    ocp_a = 1'b0;
    step(3);
    en = 1'b1;
    step(3);
    tests++;
    if (obs !== expv(1, 1, 0, 0, 0, 0)) begin
      fails++;
      $display("FAIL prio_prechg: got %b want %b", obs, expv(1, 1, 0, 0, 0, 0));
    end
    uvlo_ok = 1'b0;
    step(1);
    tests++;
    if (obs !== expv(0, 0, 0, 0, 0, 0)) begin
      fails++;
      $display("FAIL prio_uvlo_drop: got %b want %b", obs, expv(0, 0, 0, 0, 0, 0));
    end
    step(2);
    tests++;
    if (obs !== expv(0, 0, 0, 0, 0, 0)) begin
      fails++;
      $display("FAIL prio_uvlo_stay_off: got %b want %b", obs, expv(0, 0, 0, 0, 0, 0));
    end
    uvlo_ok = 1'b1;
  endtask

  task automatic test_rst_run();
    step(73);
    tests++;
    if (obs !== expv(3, 0, 1, 1, 0, 15)) begin
      fails++;
      $display("FAIL rst_run_reach: got %b want %b", obs, expv(3, 0, 1, 1, 0, 15));
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    tests++;
    if (obs !== expv(0, 0, 0, 0, 0, 0)) begin
      fails++;
      $display("FAIL rst_in_run: got %b want %b", obs, expv(0, 0, 0, 0, 0, 0));
    end
    step(1);
    tests++;
    if (obs !== expv(1, 1, 0, 0, 0, 0)) begin
      fails++;
      $display("FAIL rst_restart: got %b want %b", obs, expv(1, 1, 0, 0, 0, 0));
    end
  endtask

  task automatic test_illegal();
    step(2);
    force dut.state_q = stepdown_seq_pkg::state_t'(3'd6);
    #1;
    release dut.state_q;
    step(1);
    tests++;
    if (obs !== expv(0, 0, 0, 0, 0, 0)) begin
      fails++;
      $display("FAIL illegal_to_off: got %b want %b", obs, expv(0, 0, 0, 0, 0, 0));
    end
    step(1);
    tests++;
    if (obs !== expv(1, 1, 0, 0, 0, 0)) begin
      fails++;
      $display("FAIL illegal_recover: got %b want %b", obs, expv(1, 1, 0, 0, 0, 0));
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; en = 1'b0; uvlo_ok = 1'b0; ocp_a = 1'b0;
    test_reset();
    test_startup();
    test_ocp_retry();
    test_latch();
    test_priority();
    test_rst_run();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
